// File: rtl/viterbi_pkg.sv
// Shared constants for the rate-1/2, K=4 convolutional code
// used by the frame encoder and the Viterbi decoder.
package viterbi_pkg;

  localparam int K        = 4;
  localparam int TAIL_LEN = K - 1;

  localparam logic [K-1:0] G0 = 4'b1111;
  localparam logic [K-1:0] G1 = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    GAP
  } enc_state_t;

  function automatic logic gen_parity(
    input logic [K-1:0] g,
    input logic [K-1:0] taps
  );
    return ^(g & taps);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and generator XORs; the symbol is
// combinational from the incoming bit and the current register.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift,
  input  logic       bit_in,
  input  logic       clear,
  output logic [1:0] sym
);

  logic [K-2:0] sr;
  logic [K-1:0] taps;

  assign taps = {bit_in, sr[0], sr[1], sr[2]};

  assign sym = {gen_parity(G0, taps),
                gen_parity(G1, taps)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift) begin
      sr <= {sr[K-3:0], bit_in};
    end
  end

endmodule

// File: rtl/conv_frame_encoder.sv
// Frames a serial bit stream into data + zero tail + idle gap.
// Define CONV_ENC_ERR_INJECT_EN to add the err_mask port.
module conv_frame_encoder
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int GAP_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] d_out,
  output logic       out_valid,
  output logic       frame_done,
  output logic       underrun,
  output logic       busy
`ifdef CONV_ENC_ERR_INJECT_EN
  ,
  input  logic [1:0] err_mask
`endif
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(TAIL_LEN);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  =
    GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  enc_state_t    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic       shift;
  logic       enc_bit;
  logic       clear;
  logic [1:0] sym;
  logic [1:0] d_out_d;
  logic       frame_done_d;
  logic       underrun_d;

  conv_enc_core u_core (
    .clk    (clk),
    .rst    (rst),
    .shift  (shift),
    .bit_in (enc_bit),
    .clear  (clear),
    .sym    (sym)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tail_cnt_d   = tail_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    in_ready     = 1'b0;
    shift        = 1'b0;
    enc_bit      = 1'b0;
    clear        = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = underrun;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift      = 1'b1;
          enc_bit    = in_bit;
          underrun_d = 1'b0;
          bit_cnt_d  = CW'(1);
          tail_cnt_d = '0;
          state_d    = (FRAME_LEN == 1) ? TAIL : DATA;
        end
      end
      DATA: begin
        // A missing bit still occupies its slot so the
        // decoder's frame timing never slips.
        in_ready  = 1'b1;
        shift     = 1'b1;
        enc_bit   = in_valid & in_bit;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (!in_valid) begin
          underrun_d = 1'b1;
        end
        if (bit_cnt_q == BIT_LAST) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        shift      = 1'b1;
        tail_cnt_d = tail_cnt_q + TW'(1);
        if (tail_cnt_q == TAIL_LAST) begin
          frame_done_d = 1'b1;
          gap_cnt_d    = '0;
          state_d      = (GAP_LEN == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        clear     = 1'b1;
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CONV_ENC_ERR_INJECT_EN
  assign d_out_d = shift ? (sym ^ err_mask) : 2'b00;
`else
  assign d_out_d = shift ? sym : 2'b00;
`endif

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      gap_cnt_q  <= '0;
      d_out      <= 2'b00;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      d_out      <= d_out_d;
      out_valid  <= shift;
      frame_done <= frame_done_d;
      underrun   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed bench: one encoder with FRAME_LEN=4/GAP_LEN=2
// and one with FRAME_LEN=1/GAP_LEN=0.
module tb_conv_frame_encoder;

  logic clk;
  logic rst;

  logic       a_in_bit, a_in_valid, a_in_ready;
  logic [1:0] a_d_out;
  logic       a_out_valid, a_frame_done, a_underrun, a_busy;

  logic       b_in_bit, b_in_valid, b_in_ready;
  logic [1:0] b_d_out;
  logic       b_out_valid, b_frame_done, b_underrun, b_busy;

  int checks = 0;
  int errors = 0;

  conv_frame_encoder #(.FRAME_LEN(4), .GAP_LEN(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (a_in_bit),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .d_out      (a_d_out),
    .out_valid  (a_out_valid),
    .frame_done (a_frame_done),
    .underrun   (a_underrun),
    .busy       (a_busy)
  );

  conv_frame_encoder #(.FRAME_LEN(1), .GAP_LEN(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (b_in_bit),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .d_out      (b_d_out),
    .out_valid  (b_out_valid),
    .frame_done (b_frame_done),
    .underrun   (b_underrun),
    .busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [1:0] obs,
                     input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic a_step(input string tag,
                        input logic v, input logic b,
                        input logic [1:0] ed,
                        input logic ev, input logic efd);
    a_in_valid = v;
    a_in_bit   = b;
    @(posedge clk);
    #1;
    chk({tag, ".d_out"}, a_d_out, ed);
    chk({tag, ".out_valid"}, {1'b0, a_out_valid}, {1'b0, ev});
    chk({tag, ".frame_done"}, {1'b0, a_frame_done}, {1'b0, efd});
  endtask

  task automatic b_step(input string tag,
                        input logic v, input logic b,
                        input logic [1:0] ed,
                        input logic ev, input logic efd);
    b_in_valid = v;
    b_in_bit   = b;
    @(posedge clk);
    #1;
    chk({tag, ".d_out"}, b_d_out, ed);
    chk({tag, ".out_valid"}, {1'b0, b_out_valid}, {1'b0, ev});
    chk({tag, ".frame_done"}, {1'b0, b_frame_done}, {1'b0, efd});
  endtask

  task automatic a_gap(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, ".gap_ready"}, {1'b0, a_in_ready}, 2'b00);
      a_step({tag, ".gap"}, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    end
    chk({tag, ".idle_ready"}, {1'b0, a_in_ready}, 2'b01);
  endtask

  initial begin
    rst = 1'b1;
    a_in_bit = 1'b0; a_in_valid = 1'b0;
    b_in_bit = 1'b0; b_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.d_out", a_d_out, 2'b00);
    chk("rst.out_valid", {1'b0, a_out_valid}, 2'b00);
    chk("rst.frame_done", {1'b0, a_frame_done}, 2'b00);
    chk("rst.underrun", {1'b0, a_underrun}, 2'b00);
    chk("rst.busy", {1'b0, a_busy}, 2'b00);
    chk("rst.in_ready", {1'b0, a_in_ready}, 2'b01);
    rst = 1'b0;

    // Basic frame 1,0,1,1; in_valid stays high through tail/gap
    a_step("f1.b0", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("f1.busy", {1'b0, a_busy}, 2'b01);
    a_step("f1.b1", 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    a_step("f1.b2", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    a_step("f1.b3", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("f1.t0_ready", {1'b0, a_in_ready}, 2'b00);
    a_step("f1.t0", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    chk("f1.t1_ready", {1'b0, a_in_ready}, 2'b00);
    a_step("f1.t1", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    chk("f1.t2_ready", {1'b0, a_in_ready}, 2'b00);
    a_step("f1.t2", 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    a_gap("f1");
    chk("f1.underrun", {1'b0, a_underrun}, 2'b00);

    // Underrun on the 2nd slot; in_bit=1 there must be ignored
    a_step("f2.b0", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    a_step("f2.b1", 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("f2.underrun_set", {1'b0, a_underrun}, 2'b01);
    a_step("f2.b2", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    a_step("f2.b3", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    a_step("f2.t0", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    a_step("f2.t1", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    a_step("f2.t2", 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
    chk("f2.underrun_tail", {1'b0, a_underrun}, 2'b01);
    a_step("f2.g0", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    a_step("f2.g1", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    a_step("f2.idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("f2.underrun_idle", {1'b0, a_underrun}, 2'b01);
    chk("f2.idle_busy", {1'b0, a_busy}, 2'b00);

    // Next frame clears underrun, then async reset mid-frame
    a_step("f3.b0", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("f3.underrun_clr", {1'b0, a_underrun}, 2'b00);
    a_step("f3.b1", 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst.d_out", a_d_out, 2'b00);
    chk("mrst.out_valid", {1'b0, a_out_valid}, 2'b00);
    chk("mrst.busy", {1'b0, a_busy}, 2'b00);
    chk("mrst.in_ready", {1'b0, a_in_ready}, 2'b01);
    #1 rst = 1'b0;

    a_step("f4.b0", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    a_step("f4.b1", 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    a_step("f4.b2", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    a_step("f4.b3", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    a_step("f4.t0", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    a_step("f4.t1", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    a_step("f4.t2", 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
    a_gap("f4");

    // Data 0,1,1,0 -> 00,11,00,01 then tail 01,11,00
    a_step("f5.b0", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    a_step("f5.b1", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    a_step("f5.b2", 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    a_step("f5.b3", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    a_step("f5.t0", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    a_step("f5.t1", 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    a_step("f5.t2", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    a_step("f5.g0", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    a_in_valid = 1'b0;

    // FRAME_LEN=1, GAP_LEN=0, bit 1 held: 11, tail 11,10,11
    chk("b.idle_ready", {1'b0, b_in_ready}, 2'b01);
    b_step("b1.b0", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("b1.tail_ready", {1'b0, b_in_ready}, 2'b00);
    b_step("b1.t0", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    b_step("b1.t1", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    b_step("b1.t2", 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    chk("b1.idle_ready", {1'b0, b_in_ready}, 2'b01);
    chk("b1.idle_busy", {1'b0, b_busy}, 2'b00);
    b_step("b2.b0", 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("b2.busy", {1'b0, b_busy}, 2'b01);
    b_step("b2.t0", 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    b_step("b2.t1", 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    b_step("b2.t2", 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
    b_step("b2.idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("b.underrun", {1'b0, b_underrun}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
